// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt entry sequencer: acknowledges the injector, then runs dummy/push/vector cycles.
// Optional NMI_HIJACK_EN: an NMI arriving during an IRQ entry redirects the vector fetch to NMI.
module interrupt_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enableFFs,
  input  logic        resetDetected,
  input  logic        nmiGenerated,
  input  logic        irqGenerated,
  input  logic        processStatusRegIFlag,
  input  logic        instructionBoundary,
  input  logic [7:0]  stackPointer,
  output logic        interruptAcknowleged,
  output logic        sequenceActive,
  output logic [15:0] addressOut,
  output logic        addrOverride,
  output logic [1:0]  dataOutSel,
  output logic        writeEnable,
  output logic        decSP,
  output logic        loadPCL,
  output logic        loadPCH,
  output logic        setIFlag,
  output logic [1:0]  interruptType
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_DUMMY, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI
  } state_t;

  localparam logic [1:0] T_NONE  = 2'd0;
  localparam logic [1:0] T_IRQ   = 2'd1;
  localparam logic [1:0] T_NMI   = 2'd2;
  localparam logic [1:0] T_RESET = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  itype_q, itype_d;
  logic [15:0] vector;
  logic [15:0] stack_addr;
  logic        write_ok;

`ifdef NMI_HIJACK_EN
  logic hijack_q, hijack_d;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      hijack_q <= 1'b0;
    end else if (enableFFs) begin
      hijack_q <= hijack_d;
    end
  end
`endif

  // State and latched interrupt type advance only on enabled edges
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q <= S_IDLE;
      itype_q <= T_NONE;
    end else if (enableFFs) begin
      state_q <= state_d;
      itype_q <= itype_d;
    end
  end

  always_comb begin
    state_d = state_q;
    itype_d = itype_q;
`ifdef NMI_HIJACK_EN
    hijack_d = hijack_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (resetDetected) begin
          state_d = S_ACK;
          itype_d = T_RESET;
        end else if (nmiGenerated && instructionBoundary) begin
          state_d = S_ACK;
          itype_d = T_NMI;
        end else if (irqGenerated && !processStatusRegIFlag && instructionBoundary) begin
          state_d = S_ACK;
          itype_d = T_IRQ;
        end
      end
      S_ACK:      state_d = S_DUMMY;
      S_DUMMY:    state_d = S_PUSH_PCH;
      S_PUSH_PCH: state_d = S_PUSH_PCL;
      S_PUSH_PCL: state_d = S_PUSH_P;
      S_PUSH_P:   state_d = S_VEC_LO;
      S_VEC_LO:   state_d = S_VEC_HI;
      S_VEC_HI: begin
        state_d = S_IDLE;
        itype_d = T_NONE;
`ifdef NMI_HIJACK_EN
        hijack_d = 1'b0;
`endif
      end
      default: begin
        state_d = S_IDLE;
        itype_d = T_NONE;
      end
    endcase
`ifdef NMI_HIJACK_EN
    // An NMI seen before the vector fetch takes over an IRQ entry
    if ((state_q inside {S_ACK, S_DUMMY, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P}) &&
        itype_q == T_IRQ && nmiGenerated) begin
      itype_d  = T_NMI;
      hijack_d = 1'b1;
    end
`endif
  end

  assign stack_addr = {8'h01, stackPointer};
  assign write_ok   = (itype_q != T_RESET);

  always_comb begin
    case (itype_q)
      T_RESET: vector = RESET_VECTOR;
      T_NMI:   vector = NMI_VECTOR;
      default: vector = IRQ_VECTOR;
    endcase
  end

  // Moore decode of bus and datapath controls
  always_comb begin
    interruptAcknowleged = 1'b0;
    addressOut           = 16'h0000;
    addrOverride         = 1'b0;
    dataOutSel           = 2'd0;
    writeEnable          = 1'b0;
    decSP                = 1'b0;
    loadPCL              = 1'b0;
    loadPCH              = 1'b0;
    setIFlag             = 1'b0;
    sequenceActive       = (state_q != S_IDLE);
    interruptType        = itype_q;
    case (state_q)
      S_ACK: interruptAcknowleged = 1'b1;
      S_DUMMY: begin
        addrOverride = 1'b1;
        addressOut   = stack_addr;
      end
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
        addrOverride = 1'b1;
        addressOut   = stack_addr;
        decSP        = 1'b1;
        if (write_ok) begin
          writeEnable = 1'b1;
          case (state_q)
            S_PUSH_PCH: dataOutSel = 2'd1;
            S_PUSH_PCL: dataOutSel = 2'd2;
            default:    dataOutSel = 2'd3;
          endcase
        end
        setIFlag = (state_q == S_PUSH_P);
      end
      S_VEC_LO: begin
        addrOverride = 1'b1;
        addressOut   = vector;
        loadPCL      = 1'b1;
`ifdef NMI_HIJACK_EN
        interruptAcknowleged = hijack_q;
`endif
      end
      S_VEC_HI: begin
        addrOverride = 1'b1;
        addressOut   = vector + 16'd1;
        loadPCH      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus queues expected bus cycles, a monitor compares them.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        nrst, enableFFs, resetDetected, nmiGenerated, irqGenerated;
  logic        processStatusRegIFlag, instructionBoundary;
  logic [7:0]  stackPointer;
  logic        interruptAcknowleged, sequenceActive, addrOverride, writeEnable;
  logic        decSP, loadPCL, loadPCH, setIFlag;
  logic [15:0] addressOut;
  logic [1:0]  dataOutSel, interruptType;
  logic [26:0] dut_v;

`ifdef NMI_HIJACK_EN
  localparam bit HIJ = 1'b1;
`else
  localparam bit HIJ = 1'b0;
`endif

  typedef struct {
    logic [26:0] v;
    int          idx;
    int          nack;
  } rec_t;

  rec_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   acks_seq = 0;
  int   acks_total = 0;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk(clk), .nrst(nrst), .enableFFs(enableFFs),
    .resetDetected(resetDetected), .nmiGenerated(nmiGenerated), .irqGenerated(irqGenerated),
    .processStatusRegIFlag(processStatusRegIFlag), .instructionBoundary(instructionBoundary),
    .stackPointer(stackPointer), .interruptAcknowleged(interruptAcknowleged),
    .sequenceActive(sequenceActive), .addressOut(addressOut), .addrOverride(addrOverride),
    .dataOutSel(dataOutSel), .writeEnable(writeEnable), .decSP(decSP), .loadPCL(loadPCL),
    .loadPCH(loadPCH), .setIFlag(setIFlag), .interruptType(interruptType)
  );

  assign dut_v = {interruptAcknowleged, addrOverride, addressOut, dataOutSel, writeEnable,
                  decSP, loadPCL, loadPCH, setIFlag, interruptType};

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [26:0] pack(input bit ack, input bit ovr, input logic [15:0] addr,
                                       input logic [1:0] sel, input bit we, input bit dec,
                                       input bit lpcl, input bit lpch, input bit seti,
                                       input logic [1:0] typ);
    return {ack, ovr, addr, sel, we, dec, lpcl, lpch, seti, typ};
  endfunction

  // Reference entry: ack, dummy read at SP, three pushes at SP, SP-1, SP-2, then vector bytes
  task automatic push_seq(input int kind, input logic [7:0] sp0, input bit hij_req);
    bit          hj;
    bit          push, wr;
    logic [1:0]  typ;
    logic [15:0] vec, addr;
    logic [7:0]  spi;
    rec_t        r;
    hj = hij_req && HIJ && (kind == 1);
    for (int i = 0; i < 7; i++) begin
      typ  = (hj && i >= 2) ? 2'd2 : 2'(kind);
      vec  = (typ == 2'd3) ? 16'hFFFC : (typ == 2'd2) ? 16'hFFFA : 16'hFFFE;
      spi  = sp0 - 8'((i >= 2) ? i - 2 : 0);
      push = (i >= 2 && i <= 4);
      wr   = push && (kind != 3);
      if (i >= 1 && i <= 4) addr = {8'h01, spi};
      else if (i >= 5)      addr = vec + 16'(i - 5);
      else                  addr = 16'h0000;
      r.v    = pack((i == 0) || (hj && i == 5), i >= 1, addr, wr ? 2'(i - 1) : 2'd0, wr, push,
                    i == 5, i == 6, i == 4, typ);
      r.idx  = i;
      r.nack = hj ? 2 : 1;
      expq.push_back(r);
    end
  endtask

  task automatic monitor();
    rec_t r;
    forever begin
      @(negedge clk);
      if (sequenceActive) begin
        if (expq.size() == 0) begin
          check(1'b0, "unexpected_seq", 32'(dut_v), 32'h0);
        end else begin
          r = expq[0];
          check(dut_v === r.v, "cycle", 32'(dut_v), 32'(r.v));
          if (enableFFs) begin
            void'(expq.pop_front());
            if (r.idx == 0) acks_seq = 0;
            if (interruptAcknowleged) begin
              acks_seq++;
              acks_total++;
            end
            if (r.idx == 6) check(acks_seq == r.nack, "ack_count", 32'(acks_seq), 32'(r.nack));
          end
        end
      end else begin
        check({sequenceActive, dut_v} === 28'h0, "idle_zero", 32'({sequenceActive, dut_v}), 32'h0);
      end
    end
  endtask

  // One clock: sample at negedge, then model the datapath SP decrement after the edge
  task automatic cyc(output bit ack_o, output bit act_o);
    bit dec;
    @(negedge clk);
    dec   = decSP && enableFFs;
    ack_o = interruptAcknowleged && enableFFs;
    act_o = sequenceActive;
    @(posedge clk);
    #1;
    if (dec) stackPointer = stackPointer - 8'd1;
  endtask

  task automatic clear_flags();
    resetDetected = 1'b0;
    nmiGenerated = 1'b0;
    irqGenerated = 1'b0;
    instructionBoundary = 1'b0;
    enableFFs = 1'b1;
  endtask

  // kind: 1 IRQ, 2 NMI, 3 RESET, 4 NMI+IRQ. mode: 0 plain, 1 random gaps, 2 freeze, 3 abort, 4 hijack
  task automatic take(input int kind, input logic [7:0] sp0, input int mode);
    bit ack, act, done;
    int pos, acks;
    pos = -1;
    acks = 0;
    done = 1'b0;
    nrst = 1'b0;
    stackPointer = sp0;
    push_seq((kind == 4) ? 2 : kind, sp0, mode == 4);
    enableFFs = 1'b1;
    case (kind)
      1: begin irqGenerated = 1'b1; processStatusRegIFlag = 1'b0; instructionBoundary = 1'b1; end
      2: begin nmiGenerated = 1'b1; instructionBoundary = 1'b1; end
      3: begin resetDetected = 1'b1; instructionBoundary = 1'($urandom); end
      default: begin
        nmiGenerated = 1'b1; irqGenerated = 1'b1;
        processStatusRegIFlag = 1'($urandom); instructionBoundary = 1'b1;
      end
    endcase
    for (int n = 0; n < 80 && !done; n++) begin
      cyc(ack, act);
      if (ack) acks++;
      if (pos >= 0) pos++;
      if (ack && pos < 0) begin
        pos = 0;
        resetDetected = 1'b0;
        irqGenerated = 1'b0;
        nmiGenerated = (mode == 4);
        instructionBoundary = 1'b0;
      end
      if (mode == 4 && acks == 2) nmiGenerated = 1'b0;
      if (pos > 0 && !act) done = 1'b1;
      enableFFs = 1'b1;
      if (mode == 1 && pos >= 0) begin
        enableFFs = ($urandom_range(0, 2) != 0);
        instructionBoundary = 1'($urandom);
        processStatusRegIFlag = 1'($urandom);
      end
      if (mode == 2 && pos >= 2 && pos <= 4) enableFFs = 1'b0;
      if (mode == 3 && pos == 2) begin
        nrst = 1'b1;
        expq.delete();
        done = 1'b1;
      end
    end
    check(done, "timeout", 32'(pos), 32'h0);
    if (mode == 3) begin
      @(negedge clk);
      check({sequenceActive, dut_v} === 28'h0, "abort_zero", 32'({sequenceActive, dut_v}), 32'h0);
      @(posedge clk);
      #1;
      expq.delete();
      cyc(ack, act);
    end else begin
      check(expq.size() == 0, "drain", 32'(expq.size()), 32'h0);
    end
    clear_flags();
  endtask

  task automatic masked(input int n);
    bit ack, act;
    int a0;
    a0 = acks_total;
    irqGenerated = 1'b1;
    processStatusRegIFlag = 1'b1;
    for (int i = 0; i < n; i++) begin
      instructionBoundary = ~instructionBoundary;
      enableFFs = 1'($urandom);
      cyc(ack, act);
    end
    check(acks_total == a0, "masked_ack", 32'(acks_total), 32'(a0));
    clear_flags();
    processStatusRegIFlag = 1'b0;
  endtask

  initial begin
    bit ack, act;
    int k;
    nrst = 1'b1;
    processStatusRegIFlag = 1'b0;
    stackPointer = 8'hFD;
    clear_flags();
    fork
      monitor();
    join_none
    repeat (3) cyc(ack, act);

    take(3, 8'hFD, 0);
    take(1, 8'hFF, 0);
    masked(20);
    take(4, 8'h80, 0);
    take(1, 8'h01, 2);
    take(2, 8'h40, 3);
    take(3, 8'hFD, 0);
    take(1, 8'h30, 4);

    // A pending NMI must wait for a fresh boundary
    nmiGenerated = 1'b1;
    instructionBoundary = 1'b0;
    repeat (4) cyc(ack, act);
    take(2, 8'h22, 0);

    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(1, 5));
      if (k == 5) masked(int'($urandom_range(3, 10)));
      else take(k, 8'($urandom), int'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 3))) cyc(ack, act);
    end

    repeat (3) cyc(ack, act);
    check(expq.size() == 0, "final_drain", 32'(expq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Consumer end of the interrupt-request handshake. It takes the pending-interrupt flags (reset, NMI, IRQ) from the interrupt injector and returns the acknowledge pulse to it. It then runs the 7-cycle 6502-style interrupt entry: dummy cycle, push PCH/PCL/P, fetch the vector low and high bytes. Sits in control_logic between the injector and the datapath/address-bus muxing, and drives datapath enables while a sequence is active.

Parameters:
RESET_VECTOR, 16'hFFFC, address of the reset vector low byte
NMI_VECTOR, 16'hFFFA, address of the NMI vector low byte
IRQ_VECTOR, 16'hFFFE, address of the IRQ/BRK vector low byte

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous reset, active-high (asserted = 1); name kept per codebase
enableFFs  input  1  global clock enable; state advances only when 1
resetDetected  input  1  reset pending, from injector
nmiGenerated  input  1  NMI pending, from injector
irqGenerated  input  1  IRQ pending, from injector
processStatusRegIFlag  input  1  current I flag
instructionBoundary  input  1  high in the cycle the next opcode would be fetched
stackPointer  input  8  current SP
interruptAcknowleged  output  1  one-cycle pulse to injector
sequenceActive  output  1  high in every non-IDLE state; the core suspends normal decode
addressOut  output  16  bus address when addrOverride=1
addrOverride  output  1  the sequencer owns the address bus
dataOutSel  output  2  0=none, 1=PCH, 2=PCL, 3=P (B bit forced 0)
writeEnable  output  1  bus write strobe
decSP  output  1  decrement SP at the end of this cycle
loadPCL  output  1  latch data bus into PCL
loadPCH  output  1  latch data bus into PCH
setIFlag  output  1  set I at the end of this cycle
interruptType  output  2  0=none, 1=IRQ, 2=NMI, 3=RESET (latched)

Behaviour:
- Reset (nrst=1, async):
  - state=IDLE and interruptType=0.
  - All outputs are 0.
  - Reset asserted mid-sequence aborts to IDLE immediately; no partial writes follow.
- States: IDLE, ACK, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI. Transitions occur only on clk edges with enableFFs=1. With enableFFs=0, state and outputs hold.
- Outputs are Moore-decoded from the state register and interruptType, valid during the named state.
- IDLE -> ACK when any of these holds, in priority order:
  - resetDetected=1 (boundary not required);
  - nmiGenerated=1 and instructionBoundary=1;
  - irqGenerated=1 and processStatusRegIFlag=0 and instructionBoundary=1.
  - The winner is latched into interruptType at this edge. A masked IRQ never leaves IDLE.
- ACK: interruptAcknowleged=1 for exactly one enabled cycle; no bus override. Next state DUMMY.
- DUMMY: addrOverride=1, addressOut={8'h01,stackPointer}, read only.
- PUSH_PCH, PUSH_PCL, PUSH_P:
  - addressOut={8'h01,stackPointer}, decSP=1.
  - dataOutSel=1, 2, 3 respectively.
  - writeEnable=1, except when interruptType=RESET: writes are suppressed (writeEnable=0, dataOutSel=0) but decSP still asserts, giving a net SP−3.
  - PUSH_P also asserts setIFlag=1.
- VEC_LO: addressOut=vector, loadPCL=1.
- VEC_HI: addressOut=vector+1, loadPCH=1. The next state is IDLE and interruptType clears to 0.
- Vector selection: RESET→RESET_VECTOR, NMI→NMI_VECTOR, IRQ→IRQ_VECTOR. The +1 is a 16-bit add.
- SP wrap: the address is always page 1; SP 8'h00 decrements to 8'hFF in the datapath, with no special handling here.
- Flag changes during a sequence are ignored; no retrigger or nesting.
- New requests are evaluated only in IDLE. The exit cycle from VEC_HI → IDLE is not a boundary: the next request is taken only after instructionBoundary is asserted again.
- Latency: request+boundary edge → ACK; 7 enabled cycles from ACK through VEC_HI.

Optional Feature:
- NMI_HIJACK_EN defined:
  - If interruptType=IRQ and nmiGenerated=1 is sampled at any enabled edge while in ACK through PUSH_P, interruptType becomes NMI at that edge.
  - A second interruptAcknowleged pulse is issued in VEC_LO.
  - The vector fetch uses NMI_VECTOR; the pushed P is unchanged.
  - The bench must check exactly two ack pulses.
- Undefined: no hijack. The NMI stays pending in the injector and is taken after the next instructionBoundary.

Test Plan:
- Reset: nrst 1→0, resetDetected=1, SP=8'hFD → ACK, then 7 cycles; addresses 01FD, 01FD, 01FC, 01FB; writeEnable stays 0; VEC_LO addr FFFC with loadPCL, VEC_HI addr FFFD with loadPCH; setIFlag in PUSH_P.
- IRQ, I=0, SP=8'hFF, boundary=1 → one ack pulse; writes at 01FF (PCH), 01FE (PCL), 01FD (P, sel=3); vector FFFE/FFFF; type returns to 0.
- IRQ with I=1 and boundary toggling for 20 cycles → stays IDLE, no ack. NMI raised simultaneously with IRQ → NMI wins, vector FFFA.
- enableFFs low for 3 cycles during PUSH_PCL → state/outputs frozen, sequence still has 7 enabled cycles; SP=8'h01 → writes 0101, 0100, 01FF.
- nrst asserted during PUSH_PCL → all outputs 0 next sample. NMI_HIJACK_EN: NMI asserted in DUMMY of an IRQ → vector FFFA, two acks; without the macro, vector FFFE and one ack.
